sync_fifo_ovf: RTL and testbench

Parametrised single-clock FIFO with first-word-fall-through read and a selectable full policy. OVERWRITE=1 drops the oldest entry when a write arrives while full; OVERWRITE=0 rejects the write. It extends the earlier 2-entry write-only overwrite buffer with configurable depth, a read port, an occupancy count, threshold flags and error pulses. Used as general staging storage between producer and consumer logic in one clock domain.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_ptr.sv | 21 ++
 rtl/sync_fifo_ovf.sv | 109 ++++++++++
 tb/tb_sync_fifo_ovf.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers and full-policy encodings for the FIFO slice.
package fifo_pkg;

    // Full-policy selector values for the OVERWRITE parameter.
    localparam int POLICY_REJECT      = 0;
    localparam int POLICY_DROP_OLDEST = 1;

    // Pointer width needed to address depth entries.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Counter width able to hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer register with increment enable and synchronous active-low reset.
// Depth is a power of two, so the natural binary wrap of the register is the FIFO wrap.
module fifo_ptr #(
    parameter int PTR_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 en,
    output logic [PTR_WIDTH-1:0] ptr
);

    // Advance by one on each enabled edge, wrapping from the last index to 0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/sync_fifo_ovf.sv
// Single-clock first-word-fall-through FIFO with a selectable full policy:
// drop the oldest entry or reject the new write. Count and flags are registered
// from the next-count value; overflow/underflow are one-cycle registered pulses.
module sync_fifo_ovf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 4,
    parameter int OVERWRITE     = POLICY_DROP_OLDEST,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [DATA_WIDTH-1:0]      din,
    input  logic                       wr,
    input  logic                       rd,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [cnt_w(DEPTH)-1:0]    count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    logic                  do_write;
    logic                  do_read;
    logic                  write_blocked;
    logic [CW-1:0]         next_count;

    // Write pointer advances on every accepted write.
    fifo_ptr #(.PTR_WIDTH(PW)) u_wr_ptr (
        .clk    (clk),
        .resetn (resetn),
        .en     (do_write),
        .ptr    (wr_ptr)
    );

    // Read pointer advances on a real pop or when an overwrite evicts the oldest entry.
    fifo_ptr #(.PTR_WIDTH(PW)) u_rd_ptr (
        .clk    (clk),
        .resetn (resetn),
        .en     (do_read),
        .ptr    (rd_ptr)
    );

    // Decide what the coming edge does, using only the registered full/empty state.
    // When full with a simultaneous read, the pop frees a slot so the write is normal.
    always_comb begin
        write_blocked = 1'b0;
        do_write      = 1'b0;
        do_read       = 1'b0;
        if (wr && full && !rd) begin
            write_blocked = 1'b1;
            if (OVERWRITE == POLICY_DROP_OLDEST) begin
                do_write = 1'b1;
                do_read  = 1'b1;
            end
        end else begin
            do_write = wr;
            do_read  = rd && !empty;
        end
        next_count = count + CW'(do_write) - CW'(do_read);
    end

    // Storage: cleared on reset, written at the write pointer on accepted writes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_write) begin
            mem[wr_ptr] <= din;
        end
    end

    // Occupancy, status flags and error pulses, all registered from next_count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= (AFULL_THRESH == 0);
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            count        <= next_count;
            empty        <= (next_count == '0);
            full         <= (int'(next_count) == DEPTH);
            almost_empty <= (int'(next_count) <= AEMPTY_THRESH);
            almost_full  <= (int'(next_count) >= AFULL_THRESH);
            overflow     <= write_blocked;
            underflow    <= rd && empty;
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: tb/tb_sync_fifo_ovf.sv
// Bench for sync_fifo_ovf: one drop-oldest and one reject instance share stimulus,
// each compared every cycle against a queue-based reference model.
module tb_sync_fifo_ovf;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    typedef logic [DW-1:0] qt [$];

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic [DW-1:0] din = '0;

    logic [DW-1:0] dout_o, dout_r;
    logic          full_o, full_r, empty_o, empty_r;
    logic          af_o, af_r, ae_o, ae_r;
    logic [CW-1:0] count_o, count_r;
    logic          ovf_o, ovf_r, udf_o, udf_r;

    int n_chk  = 0;
    int n_pass = 0;

    qt  q_ovw, q_rej;
    bit fr_ovw = 1, fr_rej = 1;
    bit eovf_ovw = 0, eudf_ovw = 0, eovf_rej = 0, eudf_rej = 0;

    always #5 clk = ~clk;

    sync_fifo_ovf #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .OVERWRITE(1)) u_ovw (
        .clk(clk), .resetn(resetn), .din(din), .wr(wr), .rd(rd),
        .dout(dout_o), .full(full_o), .empty(empty_o),
        .almost_full(af_o), .almost_empty(ae_o), .count(count_o),
        .overflow(ovf_o), .underflow(udf_o)
    );

    sync_fifo_ovf #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .OVERWRITE(0)) u_rej (
        .clk(clk), .resetn(resetn), .din(din), .wr(wr), .rd(rd),
        .dout(dout_r), .full(full_r), .empty(empty_r),
        .almost_full(af_r), .almost_empty(ae_r), .count(count_r),
        .overflow(ovf_r), .underflow(udf_r)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the FIFO is a queue; the oldest element is at the front.
    task automatic model(input qt qi, input bit ovw, input bit w, input bit r, input bit rn,
                         input logic [DW-1:0] d, input bit fri,
                         output qt qo, output bit fro, output bit ovf, output bit udf);
        int n;
        qo  = qi;
        fro = fri;
        ovf = 0;
        udf = 0;
        if (!rn) begin
            qo  = {};
            fro = 1;
            return;
        end
        n = qi.size();
        if (r) begin
            if (n == 0) udf = 1;
            else void'(qo.pop_front());
        end
        if (w) begin
            if (n == DEPTH && !r) begin
                ovf = 1;
                if (ovw) begin
                    void'(qo.pop_front());
                    qo.push_back(d);
                    fro = 0;
                end
            end else begin
                qo.push_back(d);
                fro = 0;
            end
        end
    endtask

    task automatic check_one(input string p, input qt q, input bit fr, input bit eo, input bit eu,
                             input logic [DW-1:0] dout, input logic [CW-1:0] cnt,
                             input logic f, input logic e, input logic af, input logic ae,
                             input logic ov, input logic un);
        int n;
        n = q.size();
        chk({p, ".count"}, 32'(cnt), 32'(n));
        chk({p, ".full"}, 32'(f), 32'(n == DEPTH));
        chk({p, ".empty"}, 32'(e), 32'(n == 0));
        chk({p, ".almost_full"}, 32'(af), 32'(n >= DEPTH - 1));
        chk({p, ".almost_empty"}, 32'(ae), 32'(n <= 1));
        chk({p, ".overflow"}, 32'(ov), 32'(eo));
        chk({p, ".underflow"}, 32'(un), 32'(eu));
        if (n > 0) chk({p, ".dout"}, 32'(dout), 32'(q[0]));
        else if (fr) chk({p, ".dout_rst"}, 32'(dout), 32'h0);
    endtask

    task automatic cyc(input bit w, input bit r, input logic [DW-1:0] d, input bit rn = 1);
        wr = w; rd = r; din = d; resetn = rn;
        @(posedge clk);
        model(q_ovw, 1, w, r, rn, d, fr_ovw, q_ovw, fr_ovw, eovf_ovw, eudf_ovw);
        model(q_rej, 0, w, r, rn, d, fr_rej, q_rej, fr_rej, eovf_rej, eudf_rej);
        #1;
        check_one("ovw", q_ovw, fr_ovw, eovf_ovw, eudf_ovw, dout_o, count_o,
                  full_o, empty_o, af_o, ae_o, ovf_o, udf_o);
        check_one("rej", q_rej, fr_rej, eovf_rej, eudf_rej, dout_r, count_r,
                  full_r, empty_r, af_r, ae_r, ovf_r, udf_r);
    endtask

    initial begin
        int pw, pr;

        // Reset state
        cyc(0, 0, 8'h00, 0);
        cyc(0, 0, 8'h00, 1);

        // Fill to full, then write once more (drop-oldest vs reject), then drain
        cyc(1, 0, 8'h11); cyc(1, 0, 8'h22); cyc(1, 0, 8'h33); cyc(1, 0, 8'h44);
        cyc(1, 0, 8'h55);
        cyc(0, 0, 8'h00);
        for (int i = 0; i < 4; i++) cyc(0, 1, 8'h00);

        // Underflow on empty, then simultaneous write+read on empty
        cyc(0, 1, 8'h00);
        cyc(1, 1, 8'hA5);
        cyc(0, 0, 8'h00);

        // Full with simultaneous read/write across the pointer wrap
        cyc(0, 0, 8'h00, 0);
        cyc(1, 0, 8'h11); cyc(1, 0, 8'h22); cyc(1, 0, 8'h33); cyc(1, 0, 8'h44);
        for (int i = 0; i < 6; i++) cyc(1, 1, 8'h60 + 8'(i));

        // Reset with a concurrent write while half full
        cyc(0, 0, 8'h00, 0);
        cyc(1, 0, 8'h01); cyc(1, 0, 8'h02);
        cyc(1, 0, 8'h77, 0);
        cyc(0, 0, 8'h00);

        // Randomised traffic with phases that bias towards full or empty
        for (int ph = 0; ph < 8; ph++) begin
            pw = (ph % 2 == 0) ? 75 : 30;
            pr = (ph % 2 == 0) ? 30 : 70;
            for (int i = 0; i < 100; i++) begin
                cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
                    8'($urandom), $urandom_range(0, 99) >= 2);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
